// File: rtl/exact_match_lookup_pkg.sv
// Shared constants, control-state encoding and the 256-bit byte swap used by
// the exact-match lookup stage and its CAM.
package exact_match_lookup_pkg;

    localparam logic [15:0] CTRL_FLAG = 16'hf2f1;

    localparam int FLAG_OFF = 64;
    localparam int MOD_OFF  = 112;
    localparam int RESV_OFF = 120;
    localparam int IDX_OFF  = 128;

    localparam logic [3:0] RESV_KEY = 4'd0;
    localparam logic [3:0] RESV_ACT = 4'd1;
    localparam logic [3:0] RESV_INV = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARSE,
        ST_KEY_HI,
        ST_KEY_LO,
        ST_ACT,
        ST_DROP,
        ST_FWD
    } ctrl_state_t;

    // Byte 0 of the result is byte 31 of the input.
    function automatic logic [255:0] bswap256(input logic [255:0] d);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[8*(31-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/exact_match_lookup_cam.sv
// Exact-match CAM: per-entry key/valid registers, single write port,
// parallel compare and a lowest-index-wins priority encoder.
module lookup_match_cam
    import exact_match_lookup_pkg::*;
#(
    parameter int KEY_LEN     = 257,
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               wr_set,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [KEY_LEN-1:0] wr_key,
    input  logic [KEY_LEN-1:0] lookup_key,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx
);

    logic [NUM_ENTRIES-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            logic [KEY_LEN-1:0] key_q, key_d;
            logic               valid_q, valid_d;

            // A clear only drops the valid bit; the stale key is harmless.
            always_comb begin
                key_d   = key_q;
                valid_d = valid_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    valid_d = wr_set;
                    if (wr_set) begin
                        key_d = wr_key;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    key_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    key_q   <= key_d;
                    valid_q <= valid_d;
                end
            end

            assign match[gi] = valid_q && (key_q == lookup_key);
        end
    endgenerate

    always_comb begin
        hit     = |match;
        hit_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/exact_match_lookup.sv
// Match-action lookup stage: two-stage compare/action pipeline with an
// in-band control FSM that programs keys and actions over the AXIS chain.
module exact_match_lookup
    import exact_match_lookup_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int LOOKUP_ID            = 2,
    parameter int PHV_LEN              = 4*8*64+256,
    parameter int KEY_LEN              = 8*32+1,
    parameter int ACT_LEN              = 256,
    parameter int NUM_ENTRIES          = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_valid_in,
    input  logic [KEY_LEN-1:0]                key_in,
    input  logic                              key_valid_in,
    output logic                              ready_out,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_valid_out,
    output logic [ACT_LEN-1:0]                action_out,
    output logic                              action_valid_out,
    output logic                              hit_out,
    input  logic                              ready_in,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;

    logic               cam_hit, cam_wr_en, cam_wr_set;
    logic [IDX_W-1:0]   cam_idx, cam_wr_idx;
    logic [KEY_LEN-1:0] cam_wr_key;

    lookup_match_cam #(
        .KEY_LEN     (KEY_LEN),
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_cam (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (cam_wr_en),
        .wr_set     (cam_wr_set),
        .wr_idx     (cam_wr_idx),
        .wr_key     (cam_wr_key),
        .lookup_key (key_in),
        .hit        (cam_hit),
        .hit_idx    (cam_idx)
    );

    // ---------------- lookup pipeline ----------------
    logic               s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
    logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d;
    logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
    logic               out_valid_q, out_valid_d, out_hit_q, out_hit_d;
    logic [PHV_LEN-1:0] out_phv_q, out_phv_d;
    logic [ACT_LEN-1:0] out_act_q, out_act_d;
    logic [ACT_LEN-1:0] act_q [NUM_ENTRIES];
    logic [ACT_LEN-1:0] act_d [NUM_ENTRIES];
    logic               s2_ready, accept, act_wr_en;
    logic [ACT_LEN-1:0] act_wr_data;

    always_comb begin
        s2_ready    = !out_valid_q || ready_in;
        ready_out   = !s1_valid_q || s2_ready;
        accept      = phv_valid_in && key_valid_in && ready_out;
        s1_valid_d  = s1_valid_q;
        s1_phv_d    = s1_phv_q;
        s1_hit_d    = s1_hit_q;
        s1_idx_d    = s1_idx_q;
        out_valid_d = out_valid_q;
        out_phv_d   = out_phv_q;
        out_hit_d   = out_hit_q;
        out_act_d   = out_act_q;
        if (ready_out) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_phv_d = phv_in;
                s1_hit_d = cam_hit;
                s1_idx_d = cam_idx;
            end
        end
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_phv_d = s1_phv_q;
                out_hit_d = s1_hit_q;
                out_act_d = s1_hit_q ? act_q[s1_idx_q] : '0;
            end
        end
    end

    // ---------------- control FSM ----------------
    ctrl_state_t         state_q, state_d;
    logic [DW-1:0]       b0_data_q, b0_data_d, dly_data_q, dly_data_d, m_data_q, m_data_d;
    logic [UW-1:0]       b0_user_q, b0_user_d, dly_user_q, dly_user_d, m_user_q, m_user_d;
    logic [DW/8-1:0]     b0_keep_q, b0_keep_d, dly_keep_q, dly_keep_d, m_keep_q, m_keep_d;
    logic                b0_last_q, b0_last_d, dly_valid_q, dly_valid_d, dly_last_q, dly_last_d;
    logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [255:0]        key_hi_q, key_hi_d, sw;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          mod_id;
    logic [3:0]          resv;
    logic                addressed;

    always_comb begin
        sw        = bswap256(c_s_axis_tdata);
        mod_id    = c_s_axis_tdata[MOD_OFF +: 8];
        resv      = c_s_axis_tdata[RESV_OFF +: 4];
        addressed = (c_s_axis_tdata[FLAG_OFF +: 16] == CTRL_FLAG)
                 && (mod_id[7:3] == 5'(STAGE_ID)) && (mod_id[2:0] == 3'(LOOKUP_ID));

        state_d     = state_q;
        b0_data_d   = b0_data_q;
        b0_user_d   = b0_user_q;
        b0_keep_d   = b0_keep_q;
        b0_last_d   = b0_last_q;
        dly_data_d  = c_s_axis_tdata;
        dly_user_d  = c_s_axis_tuser;
        dly_keep_d  = c_s_axis_tkeep;
        dly_valid_d = c_s_axis_tvalid;
        dly_last_d  = c_s_axis_tlast;
        m_data_d    = m_data_q;
        m_user_d    = m_user_q;
        m_keep_d    = m_keep_q;
        m_valid_d   = 1'b0;
        m_last_d    = 1'b0;
        key_hi_d    = key_hi_q;
        idx_d       = idx_q;
        cam_wr_en   = 1'b0;
        cam_wr_set  = 1'b0;
        cam_wr_idx  = idx_q;
        cam_wr_key  = {key_hi_q, sw[255]};
        act_wr_en   = 1'b0;
        act_wr_data = sw[255 -: ACT_LEN];

        case (state_q)
            ST_IDLE: begin
                if (c_s_axis_tvalid) begin
                    b0_data_d = c_s_axis_tdata;
                    b0_user_d = c_s_axis_tuser;
                    b0_keep_d = c_s_axis_tkeep;
                    b0_last_d = c_s_axis_tlast;
                    state_d   = ST_PARSE;
                end
            end
            ST_PARSE: begin
                if (c_s_axis_tvalid) begin
                    idx_d = c_s_axis_tdata[IDX_OFF +: IDX_W];
                    if (addressed) begin
                        if (resv == RESV_INV) begin
                            cam_wr_en  = 1'b1;
                            cam_wr_idx = c_s_axis_tdata[IDX_OFF +: IDX_W];
                        end
                        if (c_s_axis_tlast) begin
                            state_d = ST_IDLE;
                        end else begin
                            case (resv)
                                RESV_KEY: state_d = ST_KEY_HI;
                                RESV_ACT: state_d = ST_ACT;
                                default:  state_d = ST_DROP;
                            endcase
                        end
                    end else begin
                        m_data_d  = b0_data_q;
                        m_user_d  = b0_user_q;
                        m_keep_d  = b0_keep_q;
                        m_last_d  = b0_last_q;
                        m_valid_d = 1'b1;
                        state_d   = ST_FWD;
                    end
                end
            end
            ST_KEY_HI: begin
                if (c_s_axis_tvalid) begin
                    key_hi_d = sw;
                    state_d  = c_s_axis_tlast ? ST_IDLE : ST_KEY_LO;
                end
            end
            ST_KEY_LO: begin
                if (c_s_axis_tvalid) begin
                    cam_wr_en  = !c_s_axis_tlast;
                    cam_wr_set = 1'b1;
                    state_d    = c_s_axis_tlast ? ST_IDLE : ST_DROP;
                end
            end
            ST_ACT: begin
                if (c_s_axis_tvalid) begin
                    act_wr_en = !c_s_axis_tlast;
                    state_d   = c_s_axis_tlast ? ST_IDLE : ST_DROP;
                end
            end
            ST_DROP: begin
                if (c_s_axis_tvalid && c_s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD: begin
                m_data_d  = dly_data_q;
                m_user_d  = dly_user_q;
                m_keep_d  = dly_keep_q;
                m_last_d  = dly_last_q;
                m_valid_d = dly_valid_q;
                if (dly_valid_q && dly_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            act_d[i] = act_q[i];
        end
        if (act_wr_en) begin
            act_d[idx_q] = act_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_phv_q    <= '0;
            s1_hit_q    <= 1'b0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_phv_q   <= '0;
            out_hit_q   <= 1'b0;
            out_act_q   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                act_q[i] <= '0;
            end
            state_q     <= ST_IDLE;
            b0_data_q   <= '0;
            b0_user_q   <= '0;
            b0_keep_q   <= '0;
            b0_last_q   <= 1'b0;
            dly_data_q  <= '0;
            dly_user_q  <= '0;
            dly_keep_q  <= '0;
            dly_valid_q <= 1'b0;
            dly_last_q  <= 1'b0;
            m_data_q    <= '0;
            m_user_q    <= '0;
            m_keep_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            key_hi_q    <= '0;
            idx_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_phv_q    <= s1_phv_d;
            s1_hit_q    <= s1_hit_d;
            s1_idx_q    <= s1_idx_d;
            out_valid_q <= out_valid_d;
            out_phv_q   <= out_phv_d;
            out_hit_q   <= out_hit_d;
            out_act_q   <= out_act_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                act_q[i] <= act_d[i];
            end
            state_q     <= state_d;
            b0_data_q   <= b0_data_d;
            b0_user_q   <= b0_user_d;
            b0_keep_q   <= b0_keep_d;
            b0_last_q   <= b0_last_d;
            dly_data_q  <= dly_data_d;
            dly_user_q  <= dly_user_d;
            dly_keep_q  <= dly_keep_d;
            dly_valid_q <= dly_valid_d;
            dly_last_q  <= dly_last_d;
            m_data_q    <= m_data_d;
            m_user_q    <= m_user_d;
            m_keep_q    <= m_keep_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            key_hi_q    <= key_hi_d;
            idx_q       <= idx_d;
        end
    end

    assign phv_out          = out_phv_q;
    assign phv_valid_out    = out_valid_q;
    assign action_out       = out_act_q;
    assign action_valid_out = out_valid_q;
    assign hit_out          = out_hit_q;
    assign c_m_axis_tdata   = m_data_q;
    assign c_m_axis_tuser   = m_user_q;
    assign c_m_axis_tkeep   = m_keep_q;
    assign c_m_axis_tvalid  = m_valid_q;
    assign c_m_axis_tlast   = m_last_q;

endmodule

// File: tb/tb_exact_match_lookup.sv
// Directed bench for exact_match_lookup: table programming, hit/miss/priority,
// stalled streaming, control forwarding, index wrap and mid-packet reset.
module tb_exact_match_lookup;

    localparam int PHV_LEN = 2304;
    localparam int KEY_LEN = 257;
    localparam int ACT_LEN = 256;
    localparam logic [7:0] MY_MOD    = 8'h02;
    localparam logic [7:0] OTHER_MOD = 8'h0A;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [PHV_LEN-1:0]  phv_in = '0;
    logic                phv_valid_in = 1'b0;
    logic [KEY_LEN-1:0]  key_in = '0;
    logic                key_valid_in = 1'b0;
    logic                ready_out;
    logic [PHV_LEN-1:0]  phv_out;
    logic                phv_valid_out;
    logic [ACT_LEN-1:0]  action_out;
    logic                action_valid_out;
    logic                hit_out;
    logic                ready_in = 1'b1;
    logic [255:0]        s_tdata = '0;
    logic [127:0]        s_tuser = '0;
    logic [31:0]         s_tkeep = '0;
    logic                s_tvalid = 1'b0;
    logic                s_tlast = 1'b0;
    logic [255:0]        m_tdata;
    logic [127:0]        m_tuser;
    logic [31:0]         m_tkeep;
    logic                m_tvalid;
    logic                m_tlast;

    int checks = 0;
    int failures = 0;

    exact_match_lookup dut (
        .clk              (clk),
        .rst              (rst),
        .phv_in           (phv_in),
        .phv_valid_in     (phv_valid_in),
        .key_in           (key_in),
        .key_valid_in     (key_valid_in),
        .ready_out        (ready_out),
        .phv_out          (phv_out),
        .phv_valid_out    (phv_valid_out),
        .action_out       (action_out),
        .action_valid_out (action_valid_out),
        .hit_out          (hit_out),
        .ready_in         (ready_in),
        .c_s_axis_tdata   (s_tdata),
        .c_s_axis_tuser   (s_tuser),
        .c_s_axis_tkeep   (s_tkeep),
        .c_s_axis_tvalid  (s_tvalid),
        .c_s_axis_tlast   (s_tlast),
        .c_m_axis_tdata   (m_tdata),
        .c_m_axis_tuser   (m_tuser),
        .c_m_axis_tkeep   (m_tkeep),
        .c_m_axis_tvalid  (m_tvalid),
        .c_m_axis_tlast   (m_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
        $display("check %0d %s done", checks, tag);
    endtask

    function automatic logic [255:0] tb_bswap(input logic [255:0] d);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = d[8*(31-i) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] hdr(input logic [7:0] mod, input logic [3:0] resv, input logic [7:0] idx);
        logic [255:0] d;
        d = '0;
        d[64 +: 16]  = 16'hf2f1;
        d[112 +: 8]  = mod;
        d[120 +: 4]  = resv;
        d[128 +: 8]  = idx;
        return d;
    endfunction

    task automatic beat(input logic [255:0] d, input logic last, input logic [127:0] user);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        s_tkeep  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic write_key(input logic [7:0] idx, input logic [KEY_LEN-1:0] k);
        logic [255:0] hi, lo;
        hi = k[256:1];
        lo = '0;
        lo[255] = k[0];
        beat(256'h1111, 1'b0, '0);
        beat(hdr(MY_MOD, 4'd0, idx), 1'b0, '0);
        beat(tb_bswap(hi), 1'b0, '0);
        beat(tb_bswap(lo), 1'b0, '0);
        beat('0, 1'b1, '0);
    endtask

    task automatic write_act(input logic [7:0] idx, input logic [ACT_LEN-1:0] a);
        beat(256'h2222, 1'b0, '0);
        beat(hdr(MY_MOD, 4'd1, idx), 1'b0, '0);
        beat(tb_bswap(a), 1'b0, '0);
        beat('0, 1'b1, '0);
    endtask

    task automatic lookup(input string tag, input logic [PHV_LEN-1:0] p, input logic [KEY_LEN-1:0] k,
                          input logic exp_hit, input logic [ACT_LEN-1:0] exp_act);
        ready_in     = 1'b1;
        phv_in       = p;
        key_in       = k;
        phv_valid_in = 1'b1;
        key_valid_in = 1'b1;
        @(posedge clk); #1;
        phv_valid_in = 1'b0;
        key_valid_in = 1'b0;
        chk({tag, "_lat1_valid"}, PHV_LEN'(phv_valid_out), PHV_LEN'(1'b0));
        @(posedge clk); #1;
        chk({tag, "_valid"}, PHV_LEN'(phv_valid_out), PHV_LEN'(1'b1));
        chk({tag, "_act_valid"}, PHV_LEN'(action_valid_out), PHV_LEN'(1'b1));
        chk({tag, "_hit"}, PHV_LEN'(hit_out), PHV_LEN'(exp_hit));
        chk({tag, "_action"}, PHV_LEN'(action_out), PHV_LEN'(exp_act));
        chk({tag, "_phv"}, phv_out, p);
        @(posedge clk); #1;
    endtask

    logic [KEY_LEN-1:0] k1, k2, k3, k6, k7;
    logic [ACT_LEN-1:0] a1, a3, a5, a2;
    logic [PHV_LEN-1:0] exp_phv [8];
    logic [KEY_LEN-1:0] item_key [8];
    logic [PHV_LEN-1:0] held_phv;
    logic [255:0]       fb [4];
    logic [255:0]       lo7, hi7;
    int sent, recv;
    logic stall;

    initial begin
        k1 = {1'b1, 248'h0, 8'hAB};
        k2 = {1'b0, 248'h0, 8'h5C};
        k3 = {1'b0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 128'h0, 1'b1};
        k6 = {1'b1, 64'hFACE, 192'h0};
        k7 = {1'b0, 32'h7777, 224'h9};
        a3 = {16'hDEAD, 224'h0, 16'hBEEF};
        a1 = {16'hA001, 240'h11};
        a5 = {16'hA005, 240'h55};
        a2 = {16'hA002, 240'h22};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_phv_valid", PHV_LEN'(phv_valid_out), '0);
        chk("rst_hit", PHV_LEN'(hit_out), '0);
        chk("rst_action", PHV_LEN'(action_out), '0);
        chk("rst_phv", phv_out, '0);
        chk("rst_m_tvalid", PHV_LEN'(m_tvalid), '0);
        chk("rst_ready_out", PHV_LEN'(ready_out), PHV_LEN'(1'b1));

        // 1: basic hit
        write_key(8'd3, k1);
        write_act(8'd3, a3);
        chk("wr_no_forward", PHV_LEN'(m_tvalid), '0);
        lookup("t1", {72{32'h1234_5678}}, k1, 1'b1, a3);

        // 2: miss, then invalidated entry
        lookup("t2_unprog", {72{32'h0BAD_0001}}, k2, 1'b0, '0);
        beat(256'h3333, 1'b0, '0);
        beat(hdr(MY_MOD, 4'd2, 8'd3), 1'b0, '0);
        beat('0, 1'b1, '0);
        lookup("t2_inval", {72{32'h0BAD_0002}}, k1, 1'b0, '0);

        // 3: lowest index wins
        write_key(8'd5, k3);
        write_act(8'd5, a5);
        write_key(8'd1, k3);
        write_act(8'd1, a1);
        lookup("t3_prio", {72{32'h0000_3333}}, k3, 1'b1, a1);

        // 4: eight back-to-back PHVs, ready_in toggling
        for (int i = 0; i < 8; i++) begin
            exp_phv[i]  = {72{32'hC0DE_0000 + 32'(i)}};
            item_key[i] = (i % 2 == 0) ? k3 : k2;
        end
        sent = 0;
        recv = 0;
        stall = 1'b0;
        held_phv = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            ready_in = (cyc % 2 == 0);
            if (sent < 8) begin
                phv_valid_in = 1'b1;
                key_valid_in = 1'b1;
                phv_in       = exp_phv[sent];
                key_in       = item_key[sent];
            end else begin
                phv_valid_in = 1'b0;
                key_valid_in = 1'b0;
            end
            @(negedge clk);
            if (stall) begin
                chk("t4_hold_phv", phv_out, held_phv);
                chk("t4_hold_valid", PHV_LEN'(phv_valid_out), PHV_LEN'(1'b1));
            end
            if (phv_valid_out && ready_in) begin
                chk($sformatf("t4_phv%0d", recv), phv_out, exp_phv[recv]);
                chk($sformatf("t4_hit%0d", recv), PHV_LEN'(hit_out), PHV_LEN'(recv % 2 == 0));
                chk($sformatf("t4_act%0d", recv), PHV_LEN'(action_out), (recv % 2 == 0) ? PHV_LEN'(a1) : '0);
                recv++;
            end
            stall = phv_valid_out && !ready_in;
            held_phv = phv_out;
            if (phv_valid_in && ready_out) sent++;
            @(posedge clk); #1;
        end
        phv_valid_in = 1'b0;
        key_valid_in = 1'b0;
        ready_in = 1'b1;
        chk("t4_recv_count", PHV_LEN'(recv), PHV_LEN'(8));
        chk("t4_sent_count", PHV_LEN'(sent), PHV_LEN'(8));
        @(posedge clk); #1;
        chk("t4_no_dup", PHV_LEN'(phv_valid_out), '0);

        // 5: forwarding of a packet addressed elsewhere
        fb[0] = 256'hF0F0_0000_AAAA;
        fb[1] = hdr(OTHER_MOD, 4'd0, 8'd3);
        fb[2] = {4{64'h0123_4567_89AB_CDEF}};
        fb[3] = 256'h0BEE_F000;
        beat(fb[0], 1'b0, 128'h100);
        chk("t5_b0_none", PHV_LEN'(m_tvalid), '0);
        beat(fb[1], 1'b0, 128'h101);
        chk("t5_o0_valid", PHV_LEN'(m_tvalid), PHV_LEN'(1'b1));
        chk("t5_o0_data", PHV_LEN'(m_tdata), PHV_LEN'(fb[0]));
        chk("t5_o0_user", PHV_LEN'(m_tuser), PHV_LEN'(128'h100));
        beat(fb[2], 1'b0, 128'h102);
        chk("t5_o1_data", PHV_LEN'(m_tdata), PHV_LEN'(fb[1]));
        chk("t5_o1_keep", PHV_LEN'(m_tkeep), PHV_LEN'(32'hFFFF_FFFF));
        beat(fb[3], 1'b1, 128'h103);
        chk("t5_o2_data", PHV_LEN'(m_tdata), PHV_LEN'(fb[2]));
        chk("t5_o2_last", PHV_LEN'(m_tlast), '0);
        @(posedge clk); #1;
        chk("t5_o3_data", PHV_LEN'(m_tdata), PHV_LEN'(fb[3]));
        chk("t5_o3_last", PHV_LEN'(m_tlast), PHV_LEN'(1'b1));
        chk("t5_o3_user", PHV_LEN'(m_tuser), PHV_LEN'(128'h103));
        @(posedge clk); #1;
        chk("t5_end_idle", PHV_LEN'(m_tvalid), '0);
        // forwarded key beats must not have touched entry 3
        lookup("t5_no_write", {72{32'h5555_0005}}, k1, 1'b0, '0);
        // addressed packet stays local
        beat(256'h4444, 1'b0, '0);
        chk("t5_addr_b0", PHV_LEN'(m_tvalid), '0);
        beat(hdr(MY_MOD, 4'd2, 8'd7), 1'b0, '0);
        chk("t5_addr_b1", PHV_LEN'(m_tvalid), '0);
        beat('0, 1'b1, '0);
        chk("t5_addr_b2", PHV_LEN'(m_tvalid), '0);
        @(posedge clk); #1;
        chk("t5_addr_b3", PHV_LEN'(m_tvalid), '0);

        // 6: index wrap, then reset during KEY_LO
        write_key(8'd18, k6);
        write_act(8'd2, a2);
        lookup("t6_wrap", {72{32'h6666_0018}}, k6, 1'b1, a2);
        hi7 = k7[256:1];
        lo7 = '0;
        lo7[255] = k7[0];
        beat(256'h5555, 1'b0, '0);
        beat(hdr(MY_MOD, 4'd0, 8'd9), 1'b0, '0);
        beat(tb_bswap(hi7), 1'b0, '0);
        s_tvalid = 1'b1;
        s_tdata  = tb_bswap(lo7);
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        chk("t6_rst_valid", PHV_LEN'(phv_valid_out), '0);
        chk("t6_rst_m_tvalid", PHV_LEN'(m_tvalid), '0);
        lookup("t6_partial", {72{32'h7777_0009}}, k7, 1'b0, '0);
        lookup("t6_cleared", {72{32'h7777_0002}}, k6, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
